// File: rtl/pipeline_pkg.sv
// Shared types and constants for the decode-stage pipeline control slice.
package pipeline_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CNT_W      = 16;

  // Canonical RISC-V NOP: addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Action taken by the controller in a cycle; encoding is visible on ctrl_state.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } ctrl_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between EX and the IF/ID slot.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  ifid_valid,
  input  logic [XLEN-1:0]       ifid_instruction,
  output logic                  load_use
);

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;

  assign rs1 = ifid_instruction[19:15];
  assign rs2 = ifid_instruction[24:20];

  // rs2 is compared even for formats that do not read it; a spare stall is harmless.
  always_comb begin
    load_use = idex_mem_read && (idex_rd != '0) && ifid_valid &&
               ((idex_rd == rs1) || (idex_rd == rs2));
  end

endmodule

// File: rtl/decode_stage_controller.sv
// Decode-stage controller: IF/ID register, stall/flush/freeze sequencing and event counters.
module decode_stage_controller
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       if_pc,
  input  logic [XLEN-1:0]       if_instruction,
  input  logic                  if_valid,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write_en,
  output logic [XLEN-1:0]       ifid_pc,
  output logic [XLEN-1:0]       ifid_instruction,
  output logic                  ifid_valid,
  output logic                  idex_bubble,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  ctrl_state_e      state_q, state_d;
  logic [XLEN-1:0]  ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0]  ifid_ins_q, ifid_ins_d;
  logic             ifid_val_q, ifid_val_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use;

  hazard_detect u_hazard (
    .idex_mem_read    (idex_mem_read),
    .idex_rd          (idex_rd),
    .ifid_valid       (ifid_val_q),
    .ifid_instruction (ifid_ins_q),
    .load_use         (load_use)
  );

  // Pick this cycle's action by priority and derive strobes and next register values.
  always_comb begin
    state_d     = ST_RUN;
    pc_write_en = 1'b1;
    idex_bubble = 1'b0;
    ifid_pc_d   = ifid_pc_q;
    ifid_ins_d  = ifid_ins_q;
    ifid_val_d  = ifid_val_q;
    stall_d     = stall_q;
    flush_d     = flush_q;

    if (reset) begin
      pc_write_en = 1'b0;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      state_d     = ST_FREEZE;
      pc_write_en = 1'b0;
    end else if (ex_branch_taken) begin
      state_d     = ST_FLUSH;
      idex_bubble = 1'b1;
      ifid_ins_d  = NOP_INSTR;
      ifid_val_d  = 1'b0;
      flush_d     = sat_inc(flush_q);
    end else if (load_use) begin
      state_d     = ST_STALL;
      pc_write_en = 1'b0;
      idex_bubble = 1'b1;
      stall_d     = sat_inc(stall_q);
    end else begin
      ifid_pc_d   = if_pc;
      ifid_ins_d  = if_instruction;
      ifid_val_d  = if_valid;
    end
  end

  // IF/ID slot, last action and counters; reset overrides any pending update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      ifid_pc_q  <= '0;
      ifid_ins_q <= NOP_INSTR;
      ifid_val_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_ins_q <= ifid_ins_d;
      ifid_val_q <= ifid_val_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign ctrl_state       = state_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_instruction = ifid_ins_q;
  assign ifid_valid       = ifid_val_q;
  assign stall_cycles     = stall_q;
  assign flush_count      = flush_q;

endmodule

// File: tb/tb_decode_stage_controller.sv
// Self-checking bench for decode_stage_controller against a behavioural pipeline model.
module tb_decode_stage_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, if_instruction;
  logic        if_valid, idex_mem_read, ex_branch_taken, mem_busy;
  logic [4:0]  idex_rd;
  logic        pc_write_en, ifid_valid, idex_bubble;
  logic [31:0] ifid_pc, ifid_instruction;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cycles, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the architectural state visible after each edge.
  logic [31:0] m_pc, m_ins;
  logic        m_val;
  logic [1:0]  m_state;
  int          m_stall, m_flush;

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;
  localparam logic [31:0] ADDI_X5_X0_1 = 32'h0010_0293;

  always #5 clk = ~clk;

  decode_stage_controller dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .if_instruction   (if_instruction),
    .if_valid         (if_valid),
    .idex_mem_read    (idex_mem_read),
    .idex_rd          (idex_rd),
    .ex_branch_taken  (ex_branch_taken),
    .mem_busy         (mem_busy),
    .pc_write_en      (pc_write_en),
    .ifid_pc          (ifid_pc),
    .ifid_instruction (ifid_instruction),
    .ifid_valid       (ifid_valid),
    .idex_bubble      (idex_bubble),
    .ctrl_state       (ctrl_state),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  // 0=RUN 1=STALL 2=FLUSH 3=FREEZE, chosen from the rule list in priority order.
  function automatic int model_action();
    logic [4:0] rs1, rs2;
    bit hazard;
    rs1 = m_ins[19:15];
    rs2 = m_ins[24:20];
    hazard = idex_mem_read && idex_rd != 0 && m_val && (idex_rd == rs1 || idex_rd == rs2);
    if (mem_busy) return 3;
    if (ex_branch_taken) return 2;
    if (hazard) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] model_strobes();
    int a;
    if (reset) return 2'b01;
    a = model_action();
    return {a == 0 || a == 2, a == 1 || a == 2};
  endfunction

  function automatic logic [98:0] model_regs();
    return {m_pc, m_ins, m_val, m_state, m_stall[15:0], m_flush[15:0]};
  endfunction

  // Advance the model with the currently applied inputs, then clock the DUT.
  task automatic tick();
    int a;
    if (reset) begin
      m_pc = 0; m_ins = 32'h13; m_val = 0; m_state = 0; m_stall = 0; m_flush = 0;
    end else begin
      a = model_action();
      m_state = a[1:0];
      case (a)
        0: begin m_pc = if_pc; m_ins = if_instruction; m_val = if_valid; end
        1: if (m_stall < 65535) m_stall++;
        2: begin m_ins = 32'h13; m_val = 0; if (m_flush < 65535) m_flush++; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; if_pc = $urandom; if_instruction = $urandom; if_valid = 1;
    idex_mem_read = 0; idex_rd = 0; ex_branch_taken = 0; mem_busy = 0;
  endtask

  task automatic load_ifid(input logic [31:0] ins);
    idle_inputs();
    if_instruction = ins;
    #2;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset = 1; if_pc = $urandom; if_instruction = $urandom; if_valid = $urandom;
      idex_mem_read = $urandom; idex_rd = $urandom; ex_branch_taken = $urandom; mem_busy = $urandom;
      #2;
      n_tests++;
      if ({pc_write_en, idex_bubble} !== 2'b01) begin
        n_fail++; $display("FAIL reset_strobes got=%b exp=01", {pc_write_en, idex_bubble});
      end
      tick();
      n_tests++;
      if ({ifid_pc, ifid_instruction, ifid_valid, ctrl_state, stall_cycles, flush_count} !==
          {32'h0, 32'h13, 1'b0, 2'd0, 16'h0, 16'h0}) begin
        n_fail++; $display("FAIL reset_regs got pc=%h ins=%h v=%b st=%0d s=%0d f=%0d",
                           ifid_pc, ifid_instruction, ifid_valid, ctrl_state, stall_cycles, flush_count);
      end
    end
    reset = 0;
  endtask

  task automatic test_load_use();
    logic [31:0] pc_before;
    load_ifid(ADD_X3_X1_X2);
    pc_before = ifid_pc;
    idle_inputs(); idex_mem_read = 1; idex_rd = 1;
    #2;
    n_tests++;
    if ({pc_write_en, idex_bubble} !== 2'b01) begin
      n_fail++; $display("FAIL load_use_strobes got=%b exp=01", {pc_write_en, idex_bubble});
    end
    tick();
    n_tests++;
    if ({ifid_pc, ifid_instruction, ctrl_state, stall_cycles} !== {pc_before, ADD_X3_X1_X2, 2'd1, 16'd1}) begin
      n_fail++; $display("FAIL load_use_hold got pc=%h ins=%h st=%0d s=%0d exp pc=%h ins=%h st=1 s=1",
                         ifid_pc, ifid_instruction, ctrl_state, stall_cycles, pc_before, ADD_X3_X1_X2);
    end
    idle_inputs();
    #2;
    n_tests++;
    if ({pc_write_en, idex_bubble} !== 2'b10) begin
      n_fail++; $display("FAIL load_use_release got=%b exp=10", {pc_write_en, idex_bubble});
    end
    tick();
    n_tests++;
    if (ctrl_state !== 2'd0 || stall_cycles !== 16'd1) begin
      n_fail++; $display("FAIL load_use_run got st=%0d s=%0d exp st=0 s=1", ctrl_state, stall_cycles);
    end
  endtask

  task automatic test_x0();
    load_ifid(ADDI_X5_X0_1);
    idle_inputs(); idex_mem_read = 1; idex_rd = 0;
    #2;
    n_tests++;
    if ({pc_write_en, idex_bubble} !== 2'b10) begin
      n_fail++; $display("FAIL x0_no_stall got=%b exp=10", {pc_write_en, idex_bubble});
    end
    tick();
  endtask

  task automatic test_simultaneous();
    reset = 1; #2; tick();
    load_ifid(ADD_X3_X1_X2);
    idle_inputs(); idex_mem_read = 1; idex_rd = 2; ex_branch_taken = 1;
    #2;
    n_tests++;
    if ({pc_write_en, idex_bubble} !== 2'b11) begin
      n_fail++; $display("FAIL simul_strobes got=%b exp=11", {pc_write_en, idex_bubble});
    end
    tick();
    n_tests++;
    if ({ifid_instruction, ifid_valid, ctrl_state, flush_count, stall_cycles} !==
        {32'h13, 1'b0, 2'd2, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL simul_regs got ins=%h v=%b st=%0d f=%0d s=%0d exp ins=00000013 v=0 st=2 f=1 s=0",
                         ifid_instruction, ifid_valid, ctrl_state, flush_count, stall_cycles);
    end
  endtask

  task automatic test_freeze();
    logic [98:0] snap;
    load_ifid(ADD_X3_X1_X2);
    idle_inputs(); idex_mem_read = 1; idex_rd = 1; ex_branch_taken = 1; mem_busy = 1;
    #2;
    snap = {ifid_pc, ifid_instruction, ifid_valid, 2'd3, stall_cycles, flush_count};
    for (int i = 0; i < 3; i++) begin
      if_pc = $urandom; if_instruction = $urandom;
      #1;
      n_tests++;
      if ({pc_write_en, idex_bubble} !== 2'b00) begin
        n_fail++; $display("FAIL freeze_strobes cyc=%0d got=%b exp=00", i, {pc_write_en, idex_bubble});
      end
      tick();
      n_tests++;
      if ({ifid_pc, ifid_instruction, ifid_valid, ctrl_state, stall_cycles, flush_count} !== snap) begin
        n_fail++; $display("FAIL freeze_hold cyc=%0d got st=%0d s=%0d f=%0d ins=%h",
                           i, ctrl_state, stall_cycles, flush_count, ifid_instruction);
      end
    end
    mem_busy = 0;
    #2;
    n_tests++;
    if ({pc_write_en, idex_bubble} !== 2'b11) begin
      n_fail++; $display("FAIL freeze_release got=%b exp=11", {pc_write_en, idex_bubble});
    end
    tick();
    n_tests++;
    if (ctrl_state !== 2'd2 || flush_count !== snap[15:0] + 16'd1) begin
      n_fail++; $display("FAIL freeze_flush got st=%0d f=%0d exp st=2 f=%0d", ctrl_state, flush_count, snap[15:0] + 16'd1);
    end
  endtask

  task automatic test_reset_mid_stall();
    load_ifid(ADD_X3_X1_X2);
    idle_inputs(); idex_mem_read = 1; idex_rd = 2;
    #2;
    n_tests++;
    if ({pc_write_en, idex_bubble} !== 2'b01) begin
      n_fail++; $display("FAIL mid_stall_pre got=%b exp=01", {pc_write_en, idex_bubble});
    end
    reset = 1;
    #1;
    n_tests++;
    if ({pc_write_en, idex_bubble} !== 2'b01) begin
      n_fail++; $display("FAIL mid_stall_reset_strobes got=%b exp=01", {pc_write_en, idex_bubble});
    end
    tick();
    n_tests++;
    if ({ifid_pc, ifid_instruction, ifid_valid, ctrl_state, stall_cycles, flush_count} !==
        {32'h0, 32'h13, 1'b0, 2'd0, 16'h0, 16'h0}) begin
      n_fail++; $display("FAIL mid_stall_regs got pc=%h ins=%h v=%b st=%0d s=%0d f=%0d",
                         ifid_pc, ifid_instruction, ifid_valid, ctrl_state, stall_cycles, flush_count);
    end
    reset = 0;
  endtask

  task automatic test_random();
    logic [1:0] es;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      if_pc = $urandom; if_valid = ($urandom_range(0, 4) != 0);
      if_instruction = $urandom;
      idex_mem_read = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: idex_rd = m_ins[19:15];
        1: idex_rd = m_ins[24:20];
        2: idex_rd = 0;
        default: idex_rd = $urandom;
      endcase
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 6) == 0);
      #2;
      es = model_strobes();
      n_tests++;
      if ({pc_write_en, idex_bubble} !== es) begin
        n_fail++; $display("FAIL random_strobes it=%0d got=%b exp=%b", i, {pc_write_en, idex_bubble}, es);
      end
      tick();
      n_tests++;
      if ({ifid_pc, ifid_instruction, ifid_valid, ctrl_state, stall_cycles, flush_count} !== model_regs()) begin
        n_fail++; $display("FAIL random_regs it=%0d got pc=%h ins=%h v=%b st=%0d s=%0d f=%0d exp pc=%h ins=%h v=%b st=%0d s=%0d f=%0d",
                           i, ifid_pc, ifid_instruction, ifid_valid, ctrl_state, stall_cycles, flush_count,
                           m_pc, m_ins, m_val, m_state, m_stall, m_flush);
      end
    end
    reset = 0;
  endtask

  task automatic test_saturation();
    reset = 1; #2; tick();
    load_ifid(ADD_X3_X1_X2);
    idle_inputs(); idex_mem_read = 1; idex_rd = 1;
    #2;
    for (int i = 0; i < 65534; i++) tick();
    n_tests++;
    if (stall_cycles !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_preload got=%h exp=fffe", stall_cycles);
    end
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (stall_cycles !== 16'hFFFF || m_stall != 65535) begin
      n_fail++; $display("FAIL sat_final got=%h exp=ffff", stall_cycles);
    end
    idle_inputs();
  endtask

  initial begin
    m_pc = 0; m_ins = 32'h13; m_val = 0; m_state = 0; m_stall = 0; m_flush = 0;
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_x0();
    test_simultaneous();
    test_freeze();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
